// File: rtl/fb_pkg.sv
// rtl/fb_pkg.sv - frame-buffer geometry, fill FSM states and nibble/byte-enable helpers
//   FRAME_W, FRAME_H    frame size in blokes
//   ROW_WORDS           32-bit words per frame row
//   FRAME_WORDS         words in the whole frame
//   BLOKES_PER_WORD     4-bit blokes packed per word
//   fill_state_t        rect_fill_master state encoding
//   nibble_mask()       slots lo_slot..hi_slot set
//   byte_en()           bytes touched by a nibble mask
//   partial_byte()      some touched byte has only one of its two nibbles covered
package fb_pkg;

  localparam int FRAME_W         = 320;
  localparam int FRAME_H         = 240;
  localparam int ROW_WORDS       = 40;
  localparam int FRAME_WORDS     = 'h2580;
  localparam int BLOKES_PER_WORD = 8;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ROW,
    ST_WORD,
    ST_RD,
    ST_RD_WAIT,
    ST_WRITE,
    ST_DONE
  } fill_state_t;

  function automatic logic [7:0] nibble_mask(input logic [2:0] lo_slot, input logic [2:0] hi_slot);
    logic [7:0] m;
    m = '0;
    for (int k = 0; k < 8; k++) begin
      if ((3'(k) >= lo_slot) && (3'(k) <= hi_slot)) m[k] = 1'b1;
    end
    return m;
  endfunction

  function automatic logic [3:0] byte_en(input logic [7:0] mask);
    logic [3:0] be;
    for (int i = 0; i < 4; i++) be[i] = mask[2*i] | mask[2*i+1];
    return be;
  endfunction

  function automatic logic partial_byte(input logic [7:0] mask);
    return (mask[0] ^ mask[1]) | (mask[2] ^ mask[3]) | (mask[4] ^ mask[5]) | (mask[6] ^ mask[7]);
  endfunction

endpackage

// File: rtl/rect_word_merge.sv
// rtl/rect_word_merge.sv - merges the fill colour into a word under a nibble mask
//   rdata       in  32  existing word contents (or the fill word itself for direct writes)
//   fill_color  in  4   palette index written into every masked slot
//   nib_mask    in  8   slot k covers bits [4k+3:4k]
//   wdata       out 32  merged write data
//   wr_be       out 4   byte enables for the touched bytes
module rect_word_merge
  import fb_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [3:0]  fill_color,
  input  logic [7:0]  nib_mask,
  output logic [31:0] wdata,
  output logic [3:0]  wr_be
);

  always_comb begin
    wdata = rdata;
    for (int k = 0; k < 8; k++) begin
      if (nib_mask[k]) wdata[4*k +: 4] = fill_color;
    end
    wr_be = byte_en(nib_mask);
  end

endmodule

// File: rtl/rect_fill_master.sv
// rtl/rect_fill_master.sv - Avalon-MM initiator filling a rectangle of the 4-bit frame buffer
//   CLK, RESET          clock, synchronous active-high reset
//   cmd_valid/ready     command handshake; ready only while idle
//   cmd_x/y/w/h/color   rectangle origin, size and palette index
//   busy, done          command in progress, one-cycle completion pulse
//   AVL_CS/READ/WRITE   bus strobes, one cycle each, no waitrequest
//   AVL_ADDR            word address r*ROW_WORDS + col/8
//   AVL_BYTE_EN         touched bytes of the word
//   AVL_WRITEDATA       merged write word
//   AVL_READDATA        read data, valid READ_LATENCY cycles after AVL_READ
//   Build option RECT_FILL_CLIP_EN: clip the rectangle to the frame.
module rect_fill_master
  import fb_pkg::*;
#(
  parameter int READ_LATENCY = 2
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [8:0]  cmd_x,
  input  logic [7:0]  cmd_y,
  input  logic [8:0]  cmd_w,
  input  logic [7:0]  cmd_h,
  input  logic [3:0]  cmd_color,
  output logic        busy,
  output logic        done,
  output logic        AVL_CS,
  output logic        AVL_READ,
  output logic        AVL_WRITE,
  output logic [16:0] AVL_ADDR,
  output logic [3:0]  AVL_BYTE_EN,
  output logic [31:0] AVL_WRITEDATA,
  input  logic [31:0] AVL_READDATA
);

  localparam logic [3:0] RL = 4'(READ_LATENCY);

  fill_state_t state, state_nxt;

  logic [8:0]  x0_q, x1_q;
  logic [7:0]  row_q, ybot_q;
  logic [5:0]  wcol_q;
  logic [16:0] base_q;
  logic [3:0]  color_q;
  logic [31:0] rdata_q;
  logic [3:0]  cnt_q;

  logic        accept;
  logic        acc_empty;
  logic [8:0]  acc_x1;
  logic [7:0]  acc_yb;

  assign accept = cmd_valid && (state == ST_IDLE);

`ifdef RECT_FILL_CLIP_EN
  logic [9:0] x1_full;
  logic [8:0] yb_full;
  always_comb begin
    x1_full   = {1'b0, cmd_x} + {1'b0, cmd_w} - 10'd1;
    yb_full   = {1'b0, cmd_y} + {1'b0, cmd_h} - 9'd1;
    acc_empty = (cmd_w == 9'd0) || (cmd_h == 8'd0) ||
                (cmd_x >= 9'(FRAME_W)) || (cmd_y >= 8'(FRAME_H));
    acc_x1    = (x1_full > 10'(FRAME_W - 1)) ? 9'(FRAME_W - 1) : x1_full[8:0];
    acc_yb    = (yb_full > 9'(FRAME_H - 1)) ? 8'(FRAME_H - 1) : yb_full[7:0];
  end
`else
  always_comb begin
    acc_empty = (cmd_w == 9'd0) || (cmd_h == 8'd0);
    acc_x1    = cmd_x + cmd_w - 9'd1;
    acc_yb    = cmd_y + cmd_h - 8'd1;
  end
`endif

  // Word-column bookkeeping. Only the first and last word of a row can be
  // partial, so the word after the current one always starts at slot 0.
  logic [5:0]  c0, c1, nxt_col;
  logic [2:0]  cur_lo, cur_hi, nxt_hi;
  logic [7:0]  cur_mask, nxt_mask;
  logic        last_col, last_row;
  logic [16:0] word_addr;

  always_comb begin
    c0        = x0_q[8:3];
    c1        = x1_q[8:3];
    nxt_col   = wcol_q + 6'd1;
    cur_lo    = (wcol_q == c0) ? x0_q[2:0] : 3'd0;
    cur_hi    = (wcol_q == c1) ? x1_q[2:0] : 3'd7;
    nxt_hi    = (nxt_col == c1) ? x1_q[2:0] : 3'd7;
    cur_mask  = nibble_mask(cur_lo, cur_hi);
    nxt_mask  = nibble_mask(3'd0, nxt_hi);
    last_col  = (wcol_q == c1);
    last_row  = (row_q == ybot_q);
    word_addr = base_q + {11'd0, wcol_q};
  end

  // Direct writes merge against the fill word so the whole bus word is fill.
  logic [31:0] merge_rd, m_wdata;
  logic [3:0]  m_be;

  assign merge_rd = (state == ST_WRITE) ? rdata_q : {8{color_q}};

  rect_word_merge u_merge (
    .rdata      (merge_rd),
    .fill_color (color_q),
    .nib_mask   (cur_mask),
    .wdata      (m_wdata),
    .wr_be      (m_be)
  );

  // State register
  always_ff @(posedge CLK) begin
    if (RESET) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  // Next state. The word-issue states enter ST_WORD for a direct write or
  // ST_RD for a read-modify-write, so a direct word costs a single cycle.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:    if (accept) state_nxt = acc_empty ? ST_DONE : ST_ROW;
      ST_ROW:     state_nxt = partial_byte(cur_mask) ? ST_RD : ST_WORD;
      ST_WORD, ST_WRITE: begin
        if (!last_col)      state_nxt = partial_byte(nxt_mask) ? ST_RD : ST_WORD;
        else if (!last_row) state_nxt = ST_ROW;
        else                state_nxt = ST_DONE;
      end
      ST_RD:      state_nxt = ST_RD_WAIT;
      ST_RD_WAIT: if (cnt_q == RL) state_nxt = ST_WRITE;
      ST_DONE:    state_nxt = ST_IDLE;
      default:    state_nxt = ST_IDLE;
    endcase
  end

  // Outputs
  always_comb begin
    cmd_ready     = (state == ST_IDLE);
    busy          = (state != ST_IDLE);
    done          = (state == ST_DONE);
    AVL_CS        = 1'b0;
    AVL_READ      = 1'b0;
    AVL_WRITE     = 1'b0;
    AVL_ADDR      = '0;
    AVL_BYTE_EN   = '0;
    AVL_WRITEDATA = '0;
    case (state)
      ST_RD: begin
        AVL_CS   = 1'b1;
        AVL_READ = 1'b1;
        AVL_ADDR = word_addr;
      end
      ST_WORD, ST_WRITE: begin
        AVL_CS        = 1'b1;
        AVL_WRITE     = 1'b1;
        AVL_ADDR      = word_addr;
        AVL_BYTE_EN   = m_be;
        AVL_WRITEDATA = m_wdata;
      end
      default: ;
    endcase
  end

  // Datapath
  always_ff @(posedge CLK) begin
    if (RESET) begin
      x0_q    <= '0;
      x1_q    <= '0;
      row_q   <= '0;
      ybot_q  <= '0;
      wcol_q  <= '0;
      base_q  <= '0;
      color_q <= '0;
      rdata_q <= '0;
      cnt_q   <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept) begin
            x0_q    <= cmd_x;
            x1_q    <= acc_x1;
            row_q   <= cmd_y;
            ybot_q  <= acc_yb;
            wcol_q  <= cmd_x[8:3];
            color_q <= cmd_color;
          end
        end
        // row * 40 as (row << 5) + (row << 3)
        ST_ROW: base_q <= ({9'd0, row_q} << 5) + ({9'd0, row_q} << 3);
        ST_WORD, ST_WRITE: begin
          if (!last_col) begin
            wcol_q <= nxt_col;
          end else if (!last_row) begin
            row_q  <= row_q + 8'd1;
            wcol_q <= c0;
          end
        end
        ST_RD: cnt_q <= 4'd1;
        ST_RD_WAIT: begin
          cnt_q <= cnt_q + 4'd1;
          if (cnt_q == RL) rdata_q <= AVL_READDATA;
        end
        default: ;
      endcase
    end
  end

endmodule
